// File: rtl/buf_uart_streamer_pkg.sv
// rtl/buf_uart_streamer_pkg.sv - shared state encoding and length clamp for the buffer-to-UART streamer
package buf_uart_streamer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH      = 3'd1,
    ST_LATCH      = 3'd2,
    ST_WAIT_START = 3'd3,
    ST_WAIT_DONE  = 3'd4,
    ST_FINISH     = 3'd5
  } stream_state_e;

  // Frames longer than the buffer are cut to the buffer depth so the address stays in range.
  function automatic logic [31:0] clamp_len(input logic [31:0] l, input logic [31:0] depth);
    return (l > depth) ? depth : l;
  endfunction

endpackage

// File: rtl/buf_uart_streamer_if.sv
// rtl/buf_uart_streamer_if.sv - buffer read port plus UART transmit handshake
interface buf_uart_streamer_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic              uart_transmit;
  logic [DATA_W-1:0] uart_tx_byte;
  logic              uart_is_transmitting;

  modport master (
    output ram_addr, uart_transmit, uart_tx_byte,
    input  ram_rdata, uart_is_transmitting
  );

  modport slave (
    input  ram_addr, uart_transmit, uart_tx_byte,
    output ram_rdata, uart_is_transmitting
  );
endinterface

// File: rtl/buf_uart_streamer_addr_ctr.sv
// rtl/buf_uart_streamer_addr_ctr.sv - buffer address and sent-byte counter with terminal-count compare
module stream_addr_ctr #(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              load,
  input  logic              wrap,
  input  logic              step,
  input  logic              tally,
  input  logic [ADDR_W:0]   len_in,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   count,
  output logic              last
);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] len_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      addr  <= '0;
      count <= '0;
    end else if (load) begin
      len_q <= len_in;
      addr  <= '0;
      count <= '0;
    end else if (wrap) begin
      addr  <= '0;
      count <= '0;
    end else if (step) begin
      addr  <= addr + ADDR_ONE;
      count <= count + CNT_ONE;
    end else if (tally) begin
      count <= count + CNT_ONE;
    end
  end

  // The byte in flight is the last of the pass; the address is never stepped past it.
  assign last = (count + CNT_ONE) == len_q;
endmodule

// File: rtl/buf_uart_streamer.sv
// rtl/buf_uart_streamer.sv - streams a frame of buffer bytes into the UART transmitter
module buf_uart_streamer
  import buf_uart_streamer_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 512
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                loop,
  input  logic [ADDR_W:0]     len,
  buf_uart_streamer_if.master bus,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     byte_count
);
  stream_state_e     state;
  logic              loop_q;
  logic              stop_seen;
  logic              transmit_q;
  logic [DATA_W-1:0] tx_byte_q;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   len_clamped;
  logic              last;
  logic              launch;
  logic              byte_end;
  logic              abort;
  logic              ctr_wrap;
  logic              ctr_step;
  logic              ctr_tally;

  assign len_clamped = (ADDR_W+1)'(clamp_len(32'(len), 32'(DEPTH)));
  assign launch      = (state == ST_IDLE) && start && !stop;
  assign byte_end    = (state == ST_WAIT_DONE) && !bus.uart_is_transmitting;
  assign abort       = stop_seen || stop;

  always_comb begin
    ctr_wrap  = 1'b0;
    ctr_step  = 1'b0;
    ctr_tally = 1'b0;
    if (byte_end) begin
      if (abort || (last && !loop_q)) ctr_tally = 1'b1;
      else if (last)                  ctr_wrap  = 1'b1;
      else                            ctr_step  = 1'b1;
    end
  end

  stream_addr_ctr #(.ADDR_W(ADDR_W)) u_ctr (
    .CLK    (CLK),
    .rst_n  (rst_n),
    .load   (launch),
    .wrap   (ctr_wrap),
    .step   (ctr_step),
    .tally  (ctr_tally),
    .len_in (len_clamped),
    .addr   (addr),
    .count  (byte_count),
    .last   (last)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      loop_q     <= 1'b0;
      stop_seen  <= 1'b0;
      transmit_q <= 1'b0;
      tx_byte_q  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      transmit_q <= 1'b0;
      done       <= 1'b0;
      stop_seen  <= (state == ST_IDLE) ? 1'b0 : abort;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            loop_q <= loop;
            busy   <= 1'b1;
            if (len_clamped == '0) begin
              state <= ST_FINISH;
              done  <= 1'b1;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_FETCH: state <= ST_LATCH;
        ST_LATCH: begin
          tx_byte_q  <= bus.ram_rdata;
          transmit_q <= 1'b1;
          state      <= ST_WAIT_START;
        end
        ST_WAIT_START: if (bus.uart_is_transmitting) state <= ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (byte_end) begin
            if (abort) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else if (last && !loop_q) begin
              state <= ST_FINISH;
              done  <= 1'b1;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ram_addr      = addr;
  assign bus.uart_transmit = transmit_q;
  assign bus.uart_tx_byte  = tx_byte_q;
endmodule
